boid_plotter: RTL

- Consumer side of the boid accelerator position outputs. Takes one boid update (current x/y, previous px/py, 16.16 fixed point) over a valid/ready handshake.
- Erases a BOX x BOX square at the previous position with BG_COLOR, then draws the same square at the current position with FG_COLOR.
- Writes through the M10k frame-buffer write port that the VGA reader scans out. Sits between the boid accelerator(s) and the frame-buffer arbiter.

---
 rtl/boid_plotter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/boid_plotter.sv
// Boid plotter: erases a BOX x BOX square at the previous position, then draws it at the current one.
// Latency: first write 2 cycles after accept, done 2*BOX*BOX+2 cycles after accept (BOX*BOX+2 when in_first).
// Backpressure: in_ready only while idle; each pixel slot waits for mem_grant before it is issued.
module boid_plotter #(
   parameter int                 SCREEN_W = 640,
   parameter int                 SCREEN_H = 480,
   parameter int                 ADDR_W   = 19,
   parameter int                 COLOR_W  = 8,
   parameter int                 BOX      = 2,
   parameter logic [COLOR_W-1:0] FG_COLOR = 8'hFF,
   parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_first,
   input  logic [31:0]        x,
   input  logic [31:0]        y,
   input  logic [31:0]        px,
   input  logic [31:0]        py,
   input  logic               mem_grant,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ERASE,
      ST_DRAW,
      ST_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [3:0]           dx, dy, dx_nxt, dy_nxt;
   logic signed [15:0]   cur_x, cur_y, prv_x, prv_y;
   logic signed [15:0]   base_x, base_y;
   logic [16:0]          pix_x, pix_y;
   logic                 pix_in;
   logic [ADDR_W-1:0]    pix_addr;
   logic                 last_slot;
   logic                 accept;
   logic                 wr_en_nxt;
   logic [ADDR_W-1:0]    wr_addr_nxt;
   logic [COLOR_W-1:0]   wr_data_nxt;
   logic                 done_nxt;

   // Only the integer part of each coordinate is plotted; the fraction is dropped.
   logic unused_frac;
   assign unused_frac = ^{x[15:0], y[15:0], px[15:0], py[15:0]};

   assign in_ready  = (state == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign last_slot = (dx == 4'(BOX - 1)) && (dy == 4'(BOX - 1));

   // Current slot pixel: 17-bit two's complement so negative coordinates clip instead of wrapping.
   always_comb begin
      base_x   = (state == ST_ERASE) ? prv_x : cur_x;
      base_y   = (state == ST_ERASE) ? prv_y : cur_y;
      pix_x    = {base_x[15], base_x} + {13'd0, dx};
      pix_y    = {base_y[15], base_y} + {13'd0, dy};
      pix_in   = !pix_x[16] && (pix_x < 17'(SCREEN_W)) &&
                 !pix_y[16] && (pix_y < 17'(SCREEN_H));
      pix_addr = ADDR_W'(pix_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pix_x);
   end

   // Next-state and next-output logic; a slot only advances on a granted cycle.
   always_comb begin
      state_nxt   = state;
      dx_nxt      = dx;
      dy_nxt      = dy;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = wr_addr;
      wr_data_nxt = wr_data;
      done_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt = in_first ? ST_DRAW : ST_ERASE;
               dx_nxt    = 4'd0;
               dy_nxt    = 4'd0;
            end
         end
         ST_ERASE, ST_DRAW: begin
            if (mem_grant) begin
               wr_en_nxt = pix_in;
               if (pix_in) begin
                  wr_addr_nxt = pix_addr;
                  wr_data_nxt = (state == ST_ERASE) ? BG_COLOR : FG_COLOR;
               end
               if (last_slot) begin
                  dx_nxt    = 4'd0;
                  dy_nxt    = 4'd0;
                  state_nxt = (state == ST_ERASE) ? ST_DRAW : ST_DONE;
               end else if (dx == 4'(BOX - 1)) begin
                  dx_nxt = 4'd0;
                  dy_nxt = dy + 4'd1;
               end else begin
                  dx_nxt = dx + 4'd1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and slot counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         dx    <= 4'd0;
         dy    <= 4'd0;
      end else begin
         state <= state_nxt;
         dx    <= dx_nxt;
         dy    <= dy_nxt;
      end
   end

   // Registered write port and completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
      end else begin
         wr_en   <= wr_en_nxt;
         wr_addr <= wr_addr_nxt;
         wr_data <= wr_data_nxt;
         done    <= done_nxt;
      end
   end

   // Capture integer coordinates of an accepted update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_x <= '0;
         cur_y <= '0;
         prv_x <= '0;
         prv_y <= '0;
      end else if (accept) begin
         cur_x <= x[31:16];
         cur_y <= y[31:16];
         prv_x <= px[31:16];
         prv_y <= py[31:16];
      end
   end

endmodule
